// File: rtl/seg_scan_decoder.sv
// Scan-multiplexed 7-segment display decoder with per-digit debounce and frame handshake.
// Optional: define SEG_HEX_AF_EN to decode hex letters A-F.
module seg_scan_decoder #(
   parameter int NUM_DIGITS = 4,
   parameter int STABLE_CNT = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sample_en,
   input  logic [NUM_DIGITS-1:0]     anode_n,
   input  logic [6:0]                segments_n,
   output logic [4*NUM_DIGITS-1:0]   frame_digits,
   output logic [NUM_DIGITS-1:0]     frame_blank,
   output logic [NUM_DIGITS-1:0]     frame_err,
   output logic                      frame_valid,
   input  logic                      frame_ready,
   output logic                      overrun
);

   localparam logic [3:0] STB   = 4'(STABLE_CNT);
   localparam logic [3:0] STBM1 = 4'(STABLE_CNT - 1);

   // returns {err, blank, digit}
   function automatic logic [5:0] decode(input logic [6:0] p);
      logic [5:0] r;
      case (p)
         7'b1000000: r = {2'b00, 4'h0};
         7'b1111001: r = {2'b00, 4'h1};
         7'b0100100: r = {2'b00, 4'h2};
         7'b0110000: r = {2'b00, 4'h3};
         7'b0011001: r = {2'b00, 4'h4};
         7'b0010010: r = {2'b00, 4'h5};
         7'b0000010: r = {2'b00, 4'h6};
         7'b1111000: r = {2'b00, 4'h7};
         7'b0000000: r = {2'b00, 4'h8};
         7'b0010000: r = {2'b00, 4'h9};
`ifdef SEG_HEX_AF_EN
         7'b0001000: r = {2'b00, 4'hA};
         7'b0000011: r = {2'b00, 4'hB};
         7'b1000110: r = {2'b00, 4'hC};
         7'b0100001: r = {2'b00, 4'hD};
         7'b0000110: r = {2'b00, 4'hE};
         7'b0001110: r = {2'b00, 4'hF};
`endif
         7'b1111111: r = {2'b01, 4'h0};
         default:    r = {2'b10, 4'h0};
      endcase
      return r;
   endfunction

   logic [6:0]              last_pat [NUM_DIGITS];
   logic [3:0]              cnt      [NUM_DIGITS];
   logic [4*NUM_DIGITS-1:0] wdig;
   logic [NUM_DIGITS-1:0]   wblank;
   logic [NUM_DIGITS-1:0]   werr;
   logic [NUM_DIGITS-1:0]   seen;

   logic [NUM_DIGITS-1:0]   inv;
   logic                    legal;
   logic [NUM_DIGITS-1:0]   hit;
   logic [NUM_DIGITS-1:0]   match;
   logic [NUM_DIGITS-1:0]   accept;
   logic [5:0]              dec;
   logic                    seen_all;
   logic                    load;

   assign inv      = ~anode_n;
   assign legal    = sample_en && (inv != '0) &&
                     ((inv & (inv - NUM_DIGITS'(1))) == '0);
   assign dec      = decode(segments_n);
   assign seen_all = &seen;
   assign load     = seen_all && (!frame_valid || frame_ready);

   // cnt of zero never matches, so post-reset all-off starts a fresh run
   always_comb begin
      hit    = '0;
      match  = '0;
      accept = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         hit[k]    = legal && inv[k];
         match[k]  = (segments_n == last_pat[k]) && (cnt[k] != 4'd0);
         accept[k] = hit[k] &&
                     ((STB == 4'd1) || (match[k] && (cnt[k] == STBM1)));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            last_pat[k] <= 7'b1111111;
            cnt[k]      <= 4'd0;
         end
         wdig   <= '0;
         wblank <= '0;
         werr   <= '0;
      end else begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (hit[k]) begin
               if (match[k]) begin
                  if (cnt[k] != STB)
                     cnt[k] <= cnt[k] + 4'd1;
               end else begin
                  last_pat[k] <= segments_n;
                  cnt[k]      <= 4'd1;
               end
            end
            if (accept[k]) begin
               wdig[4*k +: 4] <= dec[3:0];
               wblank[k]      <= dec[4];
               werr[k]        <= dec[5];
            end
         end
      end
   end

   // acceptance on a load edge survives the clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seen <= '0;
      end else begin
         seen <= (load ? '0 : seen) | accept;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_digits <= '0;
         frame_blank  <= '0;
         frame_err    <= '0;
         frame_valid  <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (load) begin
            frame_digits <= wdig;
            frame_blank  <= wblank;
            frame_err    <= werr;
            frame_valid  <= 1'b1;
         end else if (frame_valid && frame_ready) begin
            frame_valid  <= 1'b0;
         end
         if (seen_all && frame_valid && !frame_ready)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: vector table plus multi-cycle
// sequences for debounce, illegal samples, overrun and reset.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_en = 1'b0;
   logic [3:0]  anode_n = 4'hF;
   logic [6:0]  segments_n = 7'h7F;
   logic        frame_ready = 1'b0;
   logic [15:0] frame_digits;
   logic [3:0]  frame_blank;
   logic [3:0]  frame_err;
   logic        frame_valid;
   logic        overrun;

   seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CNT(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_en    (sample_en),
      .anode_n      (anode_n),
      .segments_n   (segments_n),
      .frame_digits (frame_digits),
      .frame_blank  (frame_blank),
      .frame_err    (frame_err),
      .frame_valid  (frame_valid),
      .frame_ready  (frame_ready),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  b;
      logic [3:0]  e;
      logic        v;
      logic        o;
   } obs_t;

   typedef struct {
      logic       en;
      logic [3:0] an;
      logic [6:0] seg;
      logic       rdy;
      obs_t       exp;
   } vec_t;

   int pass_cnt = 0;
   int total    = 0;

`ifdef SEG_HEX_AF_EN
   localparam logic [15:0] F2D = 16'h0E21;
   localparam logic [3:0]  F2E = 4'b0000;
`else
   localparam logic [15:0] F2D = 16'h0021;
   localparam logic [3:0]  F2E = 4'b0100;
`endif

   function automatic obs_t mk(input logic [15:0] d, input logic [3:0] b,
                               input logic [3:0] e, input logic v,
                               input logic o);
      obs_t r;
      r.d = d; r.b = b; r.e = e; r.v = v; r.o = o;
      return r;
   endfunction

   task automatic check(input string name, input obs_t exp);
      obs_t a;
      a = {frame_digits, frame_blank, frame_err, frame_valid, overrun};
      total++;
      if (a === exp) pass_cnt++;
      else $display("FAIL %s: got d=%h b=%b e=%b v=%b o=%b, expected d=%h b=%b e=%b v=%b o=%b",
                    name, a.d, a.b, a.e, a.v, a.o,
                    exp.d, exp.b, exp.e, exp.v, exp.o);
   endtask

   task automatic step(input logic en, input logic [3:0] an,
                       input logic [6:0] seg);
      sample_en  = en;
      anode_n    = an;
      segments_n = seg;
      @(posedge clk);
      #1;
   endtask

   task automatic scan(input int k, input logic [6:0] pat, input int n);
      logic [3:0] an;
      an    = 4'hF;
      an[k] = 1'b0;
      repeat (n) step(1'b1, an, pat);
   endtask

   task automatic idle();
      step(1'b0, 4'hF, 7'h7F);
   endtask

   vec_t vt [14];

   initial begin
      #3;
      check("reset_state", mk(16'h0, 4'h0, 4'h0, 1'b0, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         vt[i].en  = 1'b1;
         vt[i].rdy = 1'b1;
         vt[i].exp = mk(16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         vt[i].an   = 4'b1110; vt[i].seg   = 7'b0110000;
         vt[i+3].an = 4'b1101; vt[i+3].seg = 7'b1111001;
         vt[i+6].an = 4'b1011; vt[i+6].seg = 7'b0011001;
         vt[i+9].an = 4'b0111; vt[i+9].seg = 7'b1111001;
      end
      vt[12] = '{1'b0, 4'hF, 7'h7F, 1'b1, mk(16'h1413, 4'h0, 4'h0, 1'b1, 1'b0)};
      vt[13] = '{1'b0, 4'hF, 7'h7F, 1'b1, mk(16'h1413, 4'h0, 4'h0, 1'b0, 1'b0)};

      for (int i = 0; i < 14; i++) begin
         frame_ready = vt[i].rdy;
         step(vt[i].en, vt[i].an, vt[i].seg);
         check($sformatf("vec%0d", i), vt[i].exp);
      end

      // run restart on pattern change, err/blank decode, one-edge latency
      frame_ready = 1'b1;
      scan(0, 7'b1000000, 2);
      scan(0, 7'b1111001, 3);
      scan(1, 7'b0100100, 3);
      scan(2, 7'b0000110, 3);
      scan(3, 7'b1111111, 2);
      check("f2_pending", mk(16'h1413, 4'h0, 4'h0, 1'b0, 1'b0));
      scan(3, 7'b1111111, 1);
      check("f2_edgeN", mk(16'h1413, 4'h0, 4'h0, 1'b0, 1'b0));
      idle();
      check("f2_edgeN1", mk(F2D, 4'b1000, F2E, 1'b1, 1'b0));
      idle();
      check("f2_consumed", mk(F2D, 4'b1000, F2E, 1'b0, 1'b0));

      // illegal samples must not disturb two-deep runs
      for (int k = 0; k < 4; k++) scan(k, 7'b0000000, 2);
      step(1'b1, 4'b1100, 7'b1111001);
      step(1'b1, 4'b1111, 7'b1111001);
      step(1'b1, 4'b0000, 7'b1111001);
      step(1'b0, 4'b1110, 7'b1111001);
      step(1'b0, 4'b1101, 7'b1111001);
      step(1'b0, 4'b1011, 7'b1111001);
      step(1'b0, 4'b0111, 7'b1111001);
      idle();
      check("illegal_noload", mk(F2D, 4'b1000, F2E, 1'b0, 1'b0));
      for (int k = 0; k < 4; k++) scan(k, 7'b0000000, 1);
      idle();
      check("illegal_frame", mk(16'h8888, 4'h0, 4'h0, 1'b1, 1'b0));
      idle();
      check("illegal_consumed", mk(16'h8888, 4'h0, 4'h0, 1'b0, 1'b0));

      // back-pressure: second frame held off, overrun flagged
      frame_ready = 1'b0;
      scan(0, 7'b0010010, 3);
      scan(1, 7'b0000010, 3);
      scan(2, 7'b1111000, 3);
      scan(3, 7'b0010000, 3);
      idle();
      check("ovr_frameA", mk(16'h9765, 4'h0, 4'h0, 1'b1, 1'b0));
      scan(0, 7'b0110000, 3);
      scan(1, 7'b0100100, 3);
      scan(2, 7'b1111001, 3);
      scan(3, 7'b1000000, 3);
      check("ovr_held", mk(16'h9765, 4'h0, 4'h0, 1'b1, 1'b0));
      idle();
      check("ovr_set", mk(16'h9765, 4'h0, 4'h0, 1'b1, 1'b1));
      idle();
      check("ovr_still_held", mk(16'h9765, 4'h0, 4'h0, 1'b1, 1'b1));
      frame_ready = 1'b1;
      idle();
      check("ovr_frameB", mk(16'h0123, 4'h0, 4'h0, 1'b1, 1'b1));
      idle();
      check("ovr_consumed", mk(16'h0123, 4'h0, 4'h0, 1'b0, 1'b1));

      // reset mid-run discards the partial run
      scan(0, 7'b0011001, 2);
      rst = 1'b1;
      #2;
      check("midrun_reset", mk(16'h0, 4'h0, 4'h0, 1'b0, 1'b0));
      rst = 1'b0;
      for (int k = 1; k < 4; k++) scan(k, 7'b1111111, 3);
      scan(0, 7'b0011001, 2);
      idle();
      check("no_early_accept", mk(16'h0, 4'h0, 4'h0, 1'b0, 1'b0));
      scan(0, 7'b0011001, 1);
      idle();
      check("post_reset_frame", mk(16'h0004, 4'b1110, 4'h0, 1'b1, 1'b0));

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameters SHALL be: NUM_DIGITS, default 4, number of multiplexed digit positions; STABLE_CNT, default 3, consecutive identical samples needed to accept a digit (range 1..15).
REQ-002 Ports SHALL be, in order:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
sample_en  in  1  qualifies anode_n/segments_n this cycle.
anode_n  in  NUM_DIGITS  active-low digit select (one-hot-low when legal).
segments_n  in  7  active-low segments; bit0=a through bit6=g.
frame_digits  out  4*NUM_DIGITS  decoded values; digit k at [4k+3:4k].
frame_blank  out  NUM_DIGITS  digit k pattern was all-off.
frame_err  out  NUM_DIGITS  digit k pattern not in decode table.
frame_valid  out  1  frame registers hold an unconsumed frame.
frame_ready  in  1  consumer accepts the frame.
overrun  out  1  sticky: complete frame lost while frame_valid pending.

Function
REQ-003 Decode table (segments_n to digit) SHALL be: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
REQ-004 1111111 SHALL decode to digit 0, blank=1, err=0; any other pattern to digit 0, blank=0, err=1.
REQ-005 A sample SHALL be legal only when sample_en=1 and exactly one anode_n bit is 0; illegal samples change no state.
REQ-006 Per digit k, the block SHALL hold last_pat[k] and a saturating run counter cnt[k].
REQ-007 Legal sample for k with segments_n==last_pat[k]: cnt[k] increments, saturating at STABLE_CNT; otherwise last_pat[k]<=segments_n, cnt[k]<=1.
REQ-008 The sample that makes cnt[k] equal STABLE_CNT (from below) SHALL write decoded digit/blank/err into working register k and set seen[k]; saturated further samples do not re-accept.
REQ-009 With STABLE_CNT=1, every legal sample SHALL be accepted (a pattern change counts as the first of the run).
REQ-010 Frame load SHALL occur on the edge where registered seen is all-ones and (frame_valid=0 or frame_ready=1): working copied to frame outputs, frame_valid<=1, seen cleared.
REQ-011 Acceptance into seen in the same cycle as a frame load SHALL be preserved (seen bit set, not cleared).
REQ-012 frame_valid=1 and frame_ready=1 with no load SHALL clear frame_valid next edge.
REQ-013 frame outputs SHALL be stable while frame_valid=1 and frame_ready=0.
REQ-014 seen all-ones, frame_valid=1, frame_ready=0 SHALL set overrun; working registers keep updating; load deferred until ready.
REQ-015 Latency: final accepting sample at edge N gives frame_valid=1 after edge N+1.

Reset
REQ-016 rst=1 SHALL asynchronously clear: frame_digits=0, frame_blank=0, frame_err=0, frame_valid=0, overrun=0, seen=0, all cnt=0, all last_pat=7'b1111111, working registers=0.
REQ-017 Reset mid-run SHALL discard partial runs; first post-reset sample of any pattern starts cnt at 1 (all-off included, since cnt=0 breaks the match).

Configuration
REQ-018 Macro SEG_HEX_AF_EN defined: table SHALL add 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F as digits 0xA-0xF, err=0.
REQ-019 Macro SEG_HEX_AF_EN undefined: those six patterns SHALL decode as err=1, digit 0.

Verification
REQ-020 Scan digits 0..3 with 3,1,4,1 patterns, each sampled 3x consecutively, frame_ready=1 -> frame_digits=16'h1413, frame_valid one cycle, err/blank 0.
REQ-021 Digit 0 sampled 1000000,1000000,1111001,1111001,1111001 -> digit 0 accepted as 1, not 0.
REQ-022 anode_n=4'b1100 or 4'b1111 with sample_en=1 -> no cnt/seen change.
REQ-023 frame_ready=0, two full frames scanned -> first frame held, overrun=1; ready=1 -> second frame loads.
REQ-024 Pattern 0000110 on digit 2 -> err[2]=1 without SEG_HEX_AF_EN; digit 0xE, err=0 with it.
REQ-025 rst pulse after 2 of 3 samples -> no acceptance until 3 new samples, all outputs 0.
